cam_capture_px: RTL and testbench
=================================

# cam_capture_px

Parametrised DVP camera capture engine, the next generation of the OV7670 capture path. It samples the 8-bit DVP byte stream (vsync/href/d) in the pixel-clock domain and assembles 1- or 2-byte pixels. It adds single-shot/continuous frame modes, power-of-two decimation, line/frame geometry checking and a frame counter. It feeds the line-buffer controller through a valid/sof/eol pixel stream.

## Interface
Parameters:
- `BYTES_PER_PX`, default 2: bytes per pixel (1 = raw/mono, 2 = RGB565/YUV422); other values illegal.
- `H_ACTIVE`, default 640: expected pixels per href line.
- `V_ACTIVE`, default 480: expected href lines per frame.
- `CNT_W`, default 16: frame counter width.

Ports:
- `clk` in 1: pixel clock from the sensor; the only clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: arm capture; one-cycle pulse, sampled in IDLE only.
- `continuous` in 1: 1 = re-arm after each frame; 0 = single shot. Sampled with `start`.
- `stop` in 1: pulse; finish the current frame, then go to IDLE.
- `dec_x` in 2: horizontal decimation, keep 1 of 2^dec_x pixels. Latched at frame start.
- `dec_y` in 2: vertical decimation, keep 1 of 2^dec_y lines. Latched at frame start.
- `vsync` in 1: sensor VSYNC; high = vertical blanking.
- `href` in 1: sensor HREF; high = active bytes.
- `d` in 8: sensor data.
- `dout` out 8*BYTES_PER_PX: assembled pixel; first byte received sits in the MSBs.
- `dout_valid` out 1: `dout` holds a kept pixel this cycle.
- `sof` out 1: with the first `dout_valid` of a frame.
- `eol` out 1: with the last kept pixel of a kept line.
- `frame_done` out 1: one-cycle pulse at frame end.
- `busy` out 1: state is not IDLE.
- `err_line` out 1: sticky; some line length differed from H_ACTIVE.
- `err_frame` out 1: sticky; a frame's line count differed from V_ACTIVE.
- `frame_cnt` out CNT_W: frames completed; wraps.

## Operation
- Input stage: `vsync`, `href` and `d` are registered once (`*_r`). All logic below uses the registered copies.
- FSM states:
  - IDLE → ARM on `start`.
  - ARM: waits for a falling edge of `vsync_r`, then → ACTIVE. A frame already in progress at arm time is skipped.
  - ACTIVE: captures until the rising edge of `vsync_r`, then → DONE.
  - DONE (1 cycle): pulses `frame_done` and increments `frame_cnt`. Goes → ARM if `continuous` and no pending stop, else → IDLE.
- `stop` in ARM → IDLE immediately. In ACTIVE it sets a pending-stop flag, cleared on entering IDLE.
- Byte assembly:
  - A byte phase counter (0..BYTES_PER_PX-1) advances on each `href_r`=1 cycle and clears when `href_r`=0.
  - A pixel completes when phase = BYTES_PER_PX-1.
  - A trailing partial pixel at the fall of href is discarded and counts as a line-length error.
- Counters:
  - `x_cnt` counts completed pixels in the line.
  - `y_cnt` counts href falling edges in the frame.
  - Both clear at the start of ACTIVE; `x_cnt` also clears on each href fall.
- Decimation: a pixel is kept iff `x_cnt[dec_x-1:0]==0` and `y_cnt[dec_y-1:0]==0`; dec=0 keeps all.
- `eol` is raised on the kept pixel with `x_cnt` = H_ACTIVE-1-((H_ACTIVE-1) mod 2^dec_x). It is suppressed if the line ends early.
- Checks:
  - On each href fall in ACTIVE: `x_cnt`≠H_ACTIVE or partial pixel → set `err_line`.
  - On DONE: `y_cnt`≠V_ACTIVE → set `err_frame`.
  - Both flags clear only on `reset` or on `start` accepted in IDLE.
- Pixels are output only in ACTIVE; bytes seen in ARM/IDLE are ignored.

## Timing
- Latency: `dout_valid` asserts 2 cycles after the final byte of a pixel is on `d` (input register + output register).
- `dout` is held between valids. `sof`, `eol`, `frame_done` are single-cycle.
- `frame_done` fires 2 cycles after the `vsync` rise on the pins.
- Reset values: state IDLE. All outputs 0, including `frame_cnt`, `dout`, error flags and `busy`.
- Reset mid-frame: the next frame requires a new `start` and a full ARM (vsync fall).
- Simultaneous `stop` and DONE: go to IDLE. A `start` while busy is ignored.
- `frame_cnt` wraps from 2^CNT_W-1 to 0.
- Counters are sized to `$clog2(H_ACTIVE+1)` / `$clog2(V_ACTIVE+1)` and saturate at their max. They do not wrap, so overlong lines/frames still flag errors.

## Structure
- A shared package `cam_pkg` holds the FSM state enum (IDLE, ARM, ACTIVE, DONE) and the decimation-mask helper function.
- One natural sub-module, `cam_byte_pack`: byte phase counter and shift assembly, parametrised by BYTES_PER_PX. It outputs `px`, `px_done` and `partial`.

## Test plan
- BYTES_PER_PX=2, 640x480 frame, bytes 0xAB,0xCD,… → first `dout`=0xABCD with `sof`. 640 valids per line, `eol` on the 640th, `frame_done` once, `frame_cnt`=1, no errors.
- Single shot, continuous=0, two frames sent → only the first captured. `busy` drops 1 cycle after `frame_done`.
- Continuous, `stop` mid-frame 2 → frame 2 completes and `frame_cnt`=2. Frame 3 is ignored.
- dec_x=1, dec_y=2 → 320 pixels per kept line, every 4th line kept (120 lines), `eol` at x=638.
- Line 5 has 639 pixels; one line has 3 bytes (BYTES_PER_PX=2) → `err_line`=1, partial pixel dropped. A frame of 479 lines → `err_frame`=1. Next `start` clears both.
- Start asserted mid-frame, then `reset` mid-ACTIVE → first `sof` only after the next vsync fall. After reset all outputs are 0 and state is IDLE.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the DVP capture engine.
//   cam_state_e : capture FSM states
//   dec_mask()  : low-bit mask selecting 1 of 2^dec samples
package cam_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StActive,
        StDone
    } cam_state_e;

    // A sample is kept when (index & dec_mask(dec)) == 0.
    function automatic logic [7:0] dec_mask(input logic [1:0] dec);
        logic [7:0] m;
        unique case (dec)
            2'd0:    m = 8'h00;
            2'd1:    m = 8'h01;
            2'd2:    m = 8'h03;
            default: m = 8'h07;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/cam_byte_pack.sv
// Byte-to-pixel assembler for the DVP stream.
//   clk, reset : pixel clock, synchronous active-high reset
//   href, d    : registered sensor HREF and data byte
//   px         : assembled pixel, first byte of the pixel in the MSBs
//   px_done    : the byte on d completes px this cycle
//   partial    : href just fell with an incomplete pixel pending
module cam_byte_pack #(
    parameter int unsigned BYTES_PER_PX = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      href,
    input  logic [7:0]                d,
    output logic [8*BYTES_PER_PX-1:0] px,
    output logic                      px_done,
    output logic                      partial
);

    localparam int unsigned PhW = (BYTES_PER_PX > 1) ? $clog2(BYTES_PER_PX) : 1;
    localparam logic [PhW-1:0] PhLast = PhW'(BYTES_PER_PX - 1);

    logic [PhW-1:0] phase_q, phase_d;

    always_comb begin
        phase_d = '0;
        if (href && (phase_q != PhLast)) begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign px_done = href && (phase_q == PhLast);
    // Phase is forced to 0 while href is low, so a non-zero phase with href low
    // can only be the first cycle after href fell mid-pixel.
    assign partial = !href && (phase_q != '0);

    if (BYTES_PER_PX > 1) begin : g_multi
        localparam int unsigned HoldW = 8 * (BYTES_PER_PX - 1);
        logic [HoldW-1:0] hold_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                hold_q <= '0;
            end else if (href) begin
                // Keep the newest BYTES_PER_PX-1 bytes; oldest falls off the top.
                hold_q <= HoldW'({hold_q, d});
            end
        end

        assign px = {hold_q, d};
    end else begin : g_single
        assign px = d;
    end

endmodule

// File: rtl/cam_capture_px.sv
// DVP camera capture engine: registers the sensor stream, assembles pixels,
// applies power-of-two decimation and checks line/frame geometry.
//   clk, reset          : pixel clock, synchronous active-high reset
//   start, continuous   : arm capture (IDLE only); re-arm after each frame
//   stop                : finish the current frame then go idle
//   dec_x, dec_y        : keep 1 of 2^dec pixels / lines, latched at frame start
//   vsync, href, d      : raw sensor inputs
//   dout, dout_valid    : kept pixel stream (dout held between valids)
//   sof, eol            : first kept pixel of frame / last kept pixel of line
//   frame_done, busy    : end-of-frame pulse / not idle
//   err_line, err_frame : sticky geometry errors
//   frame_cnt           : completed frames, wrapping
module cam_capture_px
    import cam_pkg::*;
#(
    parameter int unsigned BYTES_PER_PX = 2,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      continuous,
    input  logic                      stop,
    input  logic [1:0]                dec_x,
    input  logic [1:0]                dec_y,
    input  logic                      vsync,
    input  logic                      href,
    input  logic [7:0]                d,
    output logic [8*BYTES_PER_PX-1:0] dout,
    output logic                      dout_valid,
    output logic                      sof,
    output logic                      eol,
    output logic                      frame_done,
    output logic                      busy,
    output logic                      err_line,
    output logic                      err_frame,
    output logic [CNT_W-1:0]          frame_cnt
);

    localparam int unsigned PxW = 8 * BYTES_PER_PX;
    localparam int unsigned XW  = $clog2(H_ACTIVE + 1);
    localparam int unsigned YW  = $clog2(V_ACTIVE + 1);

    localparam logic [XW-1:0] XMax  = '1;
    localparam logic [YW-1:0] YMax  = '1;
    localparam logic [XW-1:0] HAct  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HLast = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] VAct  = YW'(V_ACTIVE);

    // Input stage and one-cycle history for edge detection
    logic       vsync_r, href_r;
    logic [7:0] d_r;
    logic       vsync_p, href_p;

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_r <= 1'b0;
            href_r  <= 1'b0;
            d_r     <= '0;
            vsync_p <= 1'b0;
            href_p  <= 1'b0;
        end else begin
            vsync_r <= vsync;
            href_r  <= href;
            d_r     <= d;
            vsync_p <= vsync_r;
            href_p  <= href_r;
        end
    end

    logic vsync_fall, vsync_rise, href_fall;
    assign vsync_fall = vsync_p && !vsync_r;
    assign vsync_rise = !vsync_p && vsync_r;
    assign href_fall  = href_p && !href_r;

    logic [PxW-1:0] px;
    logic           px_done, partial;

    cam_byte_pack #(
        .BYTES_PER_PX(BYTES_PER_PX)
    ) u_byte_pack (
        .clk    (clk),
        .reset  (reset),
        .href   (href_r),
        .d      (d_r),
        .px     (px),
        .px_done(px_done),
        .partial(partial)
    );

    // FSM
    cam_state_e state_q, state_d;
    logic       cont_q, stop_pend_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StArm;
            end
            StArm: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (vsync_fall) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (vsync_rise) state_d = StDone;
            end
            StDone: begin
                state_d = (cont_q && !stop_pend_q && !stop) ? StArm : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath
    logic [1:0]     dec_x_q, dec_y_q;
    logic [XW-1:0]  x_cnt_q;
    logic [YW-1:0]  y_cnt_q;
    logic           sof_pend_q;
    logic [PxW-1:0] dout_q;
    logic           dout_valid_q, sof_q, eol_q;
    logic           err_line_q, err_frame_q;
    logic [CNT_W-1:0] frame_cnt_q;

    logic [XW-1:0] mask_x, eol_x;
    logic [YW-1:0] mask_y;
    logic          keep, px_keep, frame_start;

    assign mask_x      = XW'(dec_mask(dec_x_q));
    assign mask_y      = YW'(dec_mask(dec_y_q));
    // Last kept x position of a full line
    assign eol_x       = HLast & ~mask_x;
    assign keep        = ((x_cnt_q & mask_x) == '0) && ((y_cnt_q & mask_y) == '0);
    assign px_keep     = (state_q == StActive) && px_done && keep;
    assign frame_start = (state_q == StArm) && (state_d == StActive);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cont_q       <= 1'b0;
            stop_pend_q  <= 1'b0;
            dec_x_q      <= '0;
            dec_y_q      <= '0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            sof_pend_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            err_line_q   <= 1'b0;
            err_frame_q  <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q <= state_d;

            if ((state_q == StIdle) && start) begin
                cont_q      <= continuous;
                err_line_q  <= 1'b0;
                err_frame_q <= 1'b0;
            end

            if (state_d == StIdle) begin
                stop_pend_q <= 1'b0;
            end else if (stop && (state_q == StActive)) begin
                stop_pend_q <= 1'b1;
            end

            if (frame_start) begin
                dec_x_q    <= dec_x;
                dec_y_q    <= dec_y;
                x_cnt_q    <= '0;
                y_cnt_q    <= '0;
                sof_pend_q <= 1'b1;
            end else if (state_q == StActive) begin
                if (href_fall) begin
                    x_cnt_q <= '0;
                    if (y_cnt_q != YMax) y_cnt_q <= y_cnt_q + 1'b1;
                    if ((x_cnt_q != HAct) || partial) err_line_q <= 1'b1;
                end else if (px_done && (x_cnt_q != XMax)) begin
                    x_cnt_q <= x_cnt_q + 1'b1;
                end
            end

            dout_valid_q <= px_keep;
            sof_q        <= px_keep && sof_pend_q;
            eol_q        <= px_keep && (x_cnt_q == eol_x);
            if (px_keep) begin
                dout_q     <= px;
                sof_pend_q <= 1'b0;
            end

            if (state_q == StDone) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
                if (y_cnt_q != VAct) err_frame_q <= 1'b1;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sof        = sof_q;
    assign eol        = eol_q;
    assign frame_done = (state_q == StDone);
    assign busy       = (state_q != StIdle);
    assign err_line   = err_line_q;
    assign err_frame  = err_frame_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_cam_capture_px.sv
module tb_cam_capture_px;

    localparam int B  = 2;
    localparam int H  = 16;
    localparam int V  = 8;
    localparam int CW = 3;

    logic           clk = 1'b0;
    logic           reset, start, continuous, stop;
    logic [1:0]     dec_x, dec_y;
    logic           vsync, href;
    logic [7:0]     d;
    logic [8*B-1:0] dout;
    logic           dout_valid, sof, eol, frame_done, busy, err_line, err_frame;
    logic [CW-1:0]  frame_cnt;

    cam_capture_px #(
        .BYTES_PER_PX(B),
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .continuous(continuous),
        .stop      (stop),
        .dec_x     (dec_x),
        .dec_y     (dec_y),
        .vsync     (vsync),
        .href      (href),
        .d         (d),
        .dout      (dout),
        .dout_valid(dout_valid),
        .sof       (sof),
        .eol       (eol),
        .frame_done(frame_done),
        .busy      (busy),
        .err_line  (err_line),
        .err_frame (err_frame),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8*B-1:0] px;
        bit             s;
        bit             e;
    } pix_t;

    typedef struct {
        int dx;
        int dy;
        int nlines;
        int bad_line;
        int bad_bytes;
        bit exp_el;
        bit exp_ef;
    } vec_t;

    pix_t exp_q[$];
    pix_t got_q[$];
    int   checks = 0;
    int   failures = 0;
    int   n_done = 0;
    int   cnt_model = 0;

    always @(negedge clk) begin
        if (dout_valid) got_q.push_back('{px: dout, s: sof, e: eol});
        if (frame_done) n_done++;
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start(input bit cont);
        continuous = cont;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        n_done = 0;
    endtask

    function automatic bit kept(input int x, input int y);
        return ((x % (1 << dec_x)) == 0) && ((y % (1 << dec_y)) == 0);
    endfunction

    // Drives one frame: blanking, vsync fall, nlines lines, vsync rise.
    // act at line act_line: 1 = start pulse, 2 = stop pulse, 3 = reset pulse.
    task automatic drive_frame(input int nlines, input int bad_line, input int bad_bytes,
                               input bit capture, input int act_line, input int act);
        logic [7:0] lb[$];
        logic [7:0] b;
        int         nb, step, eolx;
        bit         first;
        first = 1'b1;
        step  = 1 << dec_x;
        eolx  = ((H - 1) / step) * step;
        vsync = 1'b1;
        href  = 1'b0;
        repeat (4) tick();
        vsync = 1'b0;
        repeat (3) tick();
        for (int l = 0; l < nlines; l++) begin
            if (l == act_line) begin
                if (act == 1) begin
                    pulse_start(1'b0);
                end else if (act == 2) begin
                    stop = 1'b1;
                    tick();
                    stop = 1'b0;
                end else if (act == 3) begin
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                    check("reset_mid_outputs", {dout, dout_valid, sof, eol, frame_done, busy,
                                                err_line, err_frame, frame_cnt}, 0);
                    cnt_model = 0;
                    capture = 1'b0;
                end
            end
            nb = (l == bad_line) ? bad_bytes : H * B;
            lb.delete();
            for (int i = 0; i < nb; i++) begin
                b = 8'($urandom);
                lb.push_back(b);
                href = 1'b1;
                d = b;
                tick();
            end
            href = 1'b0;
            d = 8'($urandom);
            if (capture) begin
                for (int x = 0; x < nb / B; x++) begin
                    if (kept(x, l)) begin
                        exp_q.push_back('{px: {lb[B*x], lb[B*x+1]}, s: first, e: (x == eolx)});
                        first = 1'b0;
                    end
                end
            end
            repeat (3) tick();
        end
        vsync = 1'b1;
        tick();
        if (capture) cnt_model++;
    endtask

    task automatic check_stream(input string name);
        int bad;
        int first_bad;
        int n;
        bad = 0;
        first_bad = -1;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        check({name, "/px_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < n; i++) begin
            if (got_q[i].px !== exp_q[i].px || got_q[i].s !== exp_q[i].s ||
                got_q[i].e !== exp_q[i].e) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s/stream: %0d bad pixels, first at %0d: got px=%h sof=%0d eol=%0d, expected px=%h sof=%0d eol=%0d",
                     name, bad, first_bad, got_q[first_bad].px, got_q[first_bad].s,
                     got_q[first_bad].e, exp_q[first_bad].px, exp_q[first_bad].s,
                     exp_q[first_bad].e);
        end
    endtask

    task automatic finish_checks(input string name, input int exp_done);
        check_stream(name);
        check({name, "/frame_done_count"}, n_done, exp_done);
        check({name, "/frame_cnt"}, frame_cnt, cnt_model % (1 << CW));
        check({name, "/busy_after"}, busy, 0);
    endtask

    task automatic run_case(input vec_t v, input string name);
        clear_mon();
        dec_x = 2'(v.dx);
        dec_y = 2'(v.dy);
        pulse_start(1'b0);
        check({name, "/err_clear"}, {err_line, err_frame}, 0);
        drive_frame(v.nlines, v.bad_line, v.bad_bytes, 1'b1, -1, 0);
        repeat (4) tick();
        finish_checks(name, 1);
        check({name, "/err_line"}, err_line, v.exp_el);
        check({name, "/err_frame"}, err_frame, v.exp_ef);
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        tbl[0] = '{0, 0, V,     -1,  0,         1'b0, 1'b0};
        tbl[1] = '{1, 2, V,     -1,  0,         1'b0, 1'b0};
        tbl[2] = '{0, 0, V,      5,  B*(H-1),   1'b1, 1'b0};
        tbl[3] = '{0, 0, V,      3,  3,         1'b1, 1'b0};
        tbl[4] = '{0, 0, V - 1, -1,  0,         1'b0, 1'b1};
        tbl[5] = '{2, 1, V + 1,  4,  B*(H+1),   1'b1, 1'b1};
        tbl[6] = '{3, 3, V,     -1,  0,         1'b0, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        stop = 1'b0;
        dec_x = '0;
        dec_y = '0;
        vsync = 1'b1;
        href = 1'b0;
        d = '0;
        repeat (3) tick();
        check("reset/dout", dout, 0);
        check("reset/strobes", {dout_valid, sof, eol, frame_done}, 0);
        check("reset/busy", busy, 0);
        check("reset/errors", {err_line, err_frame}, 0);
        check("reset/frame_cnt", frame_cnt, 0);
        reset = 1'b0;
        tick();

        // First pixel latency, dout hold and frame_done timing
        clear_mon();
        pulse_start(1'b0);
        check("hand/busy_armed", busy, 1);
        vsync = 1'b0;
        repeat (2) tick();
        href = 1'b1;
        d = 8'hAB;
        tick();
        d = 8'hCD;
        tick();
        check("hand/valid_early", dout_valid, 0);
        href = 1'b0;
        d = 8'h00;
        tick();
        check("hand/valid", dout_valid, 1);
        check("hand/dout", dout, 16'hABCD);
        check("hand/sof", sof, 1);
        tick();
        check("hand/valid_drop", dout_valid, 0);
        check("hand/dout_hold", dout, 16'hABCD);
        vsync = 1'b1;
        tick();
        check("hand/done_early", frame_done, 0);
        tick();
        check("hand/frame_done", frame_done, 1);
        check("hand/busy_in_done", busy, 1);
        tick();
        check("hand/busy_drop", busy, 0);
        check("hand/frame_cnt", frame_cnt, 1);
        check("hand/err_line", err_line, 1);
        check("hand/err_frame", err_frame, 1);
        cnt_model = 1;

        for (int i = 0; i < 7; i++) begin
            run_case(tbl[i], $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 5; i++) begin
            rv.dx = int'($urandom_range(0, 3));
            rv.dy = int'($urandom_range(0, 3));
            rv.nlines = V - 1 + int'($urandom_range(0, 2));
            rv.bad_line = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, V - 2)) : -1;
            rv.bad_bytes = int'($urandom_range(1, B * H + 2));
            rv.exp_el = (rv.bad_line >= 0) && (rv.bad_bytes != B * H);
            rv.exp_ef = (rv.nlines != V);
            run_case(rv, $sformatf("rnd%0d", i));
        end

        // Single shot: only the first of two frames is captured
        clear_mon();
        dec_x = '0;
        dec_y = '0;
        pulse_start(1'b0);
        drive_frame(V, -1, 0, 1'b1, -1, 0);
        drive_frame(V, -1, 0, 1'b0, -1, 0);
        repeat (4) tick();
        finish_checks("single", 1);

        // Continuous with stop during frame 2: frame 2 completes, frame 3 ignored
        clear_mon();
        pulse_start(1'b1);
        drive_frame(V, -1, 0, 1'b1, -1, 0);
        drive_frame(V, -1, 0, 1'b1, 3, 2);
        drive_frame(V, -1, 0, 1'b0, -1, 0);
        repeat (4) tick();
        finish_checks("cont_stop", 2);

        // Start mid-frame (frame skipped), reset mid-ACTIVE, then a fresh capture
        clear_mon();
        drive_frame(V, -1, 0, 1'b0, 3, 1);
        drive_frame(V, -1, 0, 1'b1, 4, 3);
        repeat (2) tick();
        check("mid/busy_after_reset", busy, 0);
        pulse_start(1'b0);
        drive_frame(V, -1, 0, 1'b1, -1, 0);
        repeat (4) tick();
        finish_checks("mid", 1);
        check("mid/errors", {err_line, err_frame}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
